// File: rtl/imem_loader_ctrl.sv
// ---------------------------------------------------------------------------
// imem_loader_ctrl
//
// Boot / program-load controller for the multicycle core's shared data
// memory. While a load is in progress the core is held in reset and the
// controller owns the external dmem path (IEA/IED/XWE selects). Host words
// are written to consecutive word addresses starting at BASE. The words are
// then read back and summed. The core is released only if the read-back sum
// matches the sum of the written words. On a mismatch, err is raised and the
// core stays held.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   start          single-cycle pulse that begins a load (IDLE/RUN/FAIL only)
//   load_len       requested word count, sampled on start, clamped to DEPTH
//   s_valid/s_data host word stream; s_ready = controller accepts this cycle
//   rdata          dmem read data (asynchronous read of ext_addr)
//   ext_sel        1 = controller owns the dmem address/data/we path
//   ext_we         dmem write enable (combinational from s_valid in LOAD)
//   ext_addr       dmem byte address, BASE + 4*(idx mod DEPTH) in the window
//   ext_wdata      dmem write data
//   cpu_hold       OR'd into the core reset
//   done / err     load verified and core running / verify mismatch
//   checksum       modulo-2^Width sum of the words written in this load
//   words_loaded   handshakes accepted in the current load
// ---------------------------------------------------------------------------
module imem_loader_ctrl #(
  parameter int Width = 32,
  parameter int DEPTH = 128,
  parameter int BASE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       load_len,
  input  logic             s_valid,
  input  logic [Width-1:0] s_data,
  output logic             s_ready,
  input  logic [Width-1:0] rdata,
  output logic             ext_sel,
  output logic             ext_we,
  output logic [Width-1:0] ext_addr,
  output logic [Width-1:0] ext_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [Width-1:0] checksum,
  output logic [7:0]       words_loaded
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [Width-1:0] BASE_V = Width'(BASE);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_VERIFY = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_FAIL   = 3'd5;

  logic [2:0]       state_reg, state_next;
  logic [7:0]       len_reg, len_next;
  logic [7:0]       idx_reg, idx_next;
  logic [Width-1:0] csum_reg, csum_next;
  logic [Width-1:0] rsum_reg, rsum_next;
  logic [7:0]       wl_reg, wl_next;

  logic [7:0]       start_len;
  logic [7:0]       last_idx;
  logic [AW-1:0]    word_off;

  // Requested length clamped to the memory size.
  assign start_len = ({1'b0, load_len} > 9'(DEPTH)) ? 8'(DEPTH) : load_len;
  assign last_idx  = len_reg - 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      len_reg   <= '0;
      idx_reg   <= '0;
      csum_reg  <= '0;
      rsum_reg  <= '0;
      wl_reg    <= '0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      csum_reg  <= csum_next;
      rsum_reg  <= rsum_next;
      wl_reg    <= wl_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    csum_next  = csum_reg;
    rsum_next  = rsum_reg;
    wl_next    = wl_reg;
    case (state_reg)
      ST_IDLE, ST_RUN, ST_FAIL: begin
        if (start) begin
          len_next   = start_len;
          idx_next   = '0;
          csum_next  = '0;
          rsum_next  = '0;
          wl_next    = '0;
          // An empty load has nothing to verify: release the core directly.
          state_next = (start_len == 8'd0) ? ST_RUN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          csum_next = csum_reg + s_data;
          wl_next   = wl_reg + 8'd1;
          if (idx_reg == last_idx) begin
            idx_next   = '0;
            state_next = ST_VERIFY;
          end else begin
            idx_next = idx_reg + 8'd1;
          end
        end
      end
      ST_VERIFY: begin
        // rdata is the asynchronous read of the address presented this cycle.
        rsum_next = rsum_reg + rdata;
        if (idx_reg == last_idx) begin
          idx_next   = '0;
          state_next = ST_CHECK;
        end else begin
          idx_next = idx_reg + 8'd1;
        end
      end
      ST_CHECK: begin
        state_next = (rsum_reg == csum_reg) ? ST_RUN : ST_FAIL;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Word offset wraps inside the DEPTH-word window; bits above the window
  // come from BASE only, so a full-depth load never leaves dmem.
  assign word_off = BASE_V[AW+1:2] + AW'(idx_reg);

  generate
    if (Width > AW + 2) begin : g_addr_hi
      assign ext_addr = {BASE_V[Width-1:AW+2], word_off, 2'b00};
    end else begin : g_addr_lo
      assign ext_addr = {word_off, 2'b00};
    end
  endgenerate

  assign s_ready      = (state_reg == ST_LOAD);
  assign ext_sel      = (state_reg == ST_LOAD) || (state_reg == ST_VERIFY) ||
                        (state_reg == ST_CHECK);
  assign ext_we       = s_ready && s_valid;
  assign ext_wdata    = s_ready ? s_data : '0;
  assign cpu_hold     = (state_reg != ST_RUN);
  assign done         = (state_reg == ST_RUN);
  assign err          = (state_reg == ST_FAIL);
  assign checksum     = csum_reg;
  assign words_loaded = wl_reg;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_loader_ctrl
//
// Two controller instances (BASE=0 and BASE=0x100) share one clock, each with
// its own dmem model (synchronous write, asynchronous read, optional
// corruption of one read-back address). Directed and randomised loads are
// checked against a reference computed from the load rules: expected byte
// addresses, running sums, cycle-exact phase lengths and the final verdict.
// ---------------------------------------------------------------------------
module tb_imem_loader_ctrl;

  localparam int W  = 32;
  localparam int D  = 128;
  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_s        [NI];
  logic         start_s        [NI];
  logic [7:0]   load_len_s     [NI];
  logic         s_valid_s      [NI];
  logic [W-1:0] s_data_s       [NI];
  logic         s_ready_s      [NI];
  logic [W-1:0] rdata_s        [NI];
  logic         ext_sel_s      [NI];
  logic         ext_we_s       [NI];
  logic [W-1:0] ext_addr_s     [NI];
  logic [W-1:0] ext_wdata_s    [NI];
  logic         cpu_hold_s     [NI];
  logic         done_s         [NI];
  logic         err_s          [NI];
  logic [W-1:0] checksum_s     [NI];
  logic [7:0]   words_loaded_s [NI];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      imem_loader_ctrl #(
        .Width(W),
        .DEPTH(D),
        .BASE (gi * 256)
      ) u_dut (
        .clk         (clk),
        .reset       (reset_s[gi]),
        .start       (start_s[gi]),
        .load_len    (load_len_s[gi]),
        .s_valid     (s_valid_s[gi]),
        .s_data      (s_data_s[gi]),
        .s_ready     (s_ready_s[gi]),
        .rdata       (rdata_s[gi]),
        .ext_sel     (ext_sel_s[gi]),
        .ext_we      (ext_we_s[gi]),
        .ext_addr    (ext_addr_s[gi]),
        .ext_wdata   (ext_wdata_s[gi]),
        .cpu_hold    (cpu_hold_s[gi]),
        .done        (done_s[gi]),
        .err         (err_s[gi]),
        .checksum    (checksum_s[gi]),
        .words_loaded(words_loaded_s[gi])
      );
    end
  endgenerate

  // dmem models and write log
  typedef struct {
    int          k;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t          wlog [$];
  logic [W-1:0] mem [NI][D];
  logic         corrupt_en;
  int           corrupt_inst;
  logic [31:0]  corrupt_addr;
  logic [31:0]  corrupt_val;

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (ext_sel_s[k] && ext_we_s[k]) begin
        mem[k][ext_addr_s[k][8:2]] <= ext_wdata_s[k];
        wlog.push_back('{k, ext_addr_s[k], ext_wdata_s[k]});
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NI; k++) begin
      rdata_s[k] = mem[k][ext_addr_s[k][8:2]];
      if (corrupt_en && corrupt_inst == k && ext_addr_s[k] == corrupt_addr)
        rdata_s[k] = corrupt_val;
    end
  end

  // bookkeeping
  int           tests = 0;
  int           fails = 0;
  logic [31:0]  words [256];
  logic         model_run [NI];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int k);
    return (k == 0) ? 32'h0 : 32'h100;
  endfunction

  // Byte address of the i-th word: BASE + 4*i folded into the 512-byte window.
  function automatic logic [31:0] exp_addr(input int k, input int i);
    logic [31:0] b;
    b = base_of(k);
    return (b & ~32'h1FF) | ((b + 32'(i) * 32'd4) & 32'h1FF);
  endfunction

  // One complete load on instance k. mode: 0 = s_valid always high,
  // 1 = s_valid toggles (low first), 2 = random s_valid.
  // abort_at >= 0 pulses reset during that VERIFY word.
  task automatic run_load(input int k, input int req, input int mode, input int abort_at);
    int          len;
    int          i;
    int          cyc;
    int          wr0;
    logic        v;
    logic        exp_ok;
    logic [31:0] wsum;
    logic [31:0] rsum;
    logic [31:0] rv;
    wr_t         e;

    len = (req > D) ? D : req;
    wr0 = wlog.size();

    @(negedge clk);
    start_s[k]    = 1'b1;
    load_len_s[k] = 8'(req);
    #1;
    if (model_run[k]) chk1("run_hold_before_start", cpu_hold_s[k], 1'b0);
    @(negedge clk);
    start_s[k] = 1'b0;
    #1;

    if (len == 0) begin
      chk1("empty_done", done_s[k], 1'b1);
      chk1("empty_hold", cpu_hold_s[k], 1'b0);
      chk1("empty_sel", ext_sel_s[k], 1'b0);
      chk1("empty_err", err_s[k], 1'b0);
      chk("empty_csum", checksum_s[k], 32'h0);
      chk("empty_wl", 32'(words_loaded_s[k]), 32'h0);
      chk("empty_writes", 32'(wlog.size() - wr0), 32'h0);
      model_run[k] = 1'b1;
      $display("[TB] load inst=%0d req=%0d len=0 -> run without writes", k, req);
      return;
    end

    chk1("entry_ready", s_ready_s[k], 1'b1);
    chk1("entry_hold", cpu_hold_s[k], 1'b1);
    chk1("entry_done", done_s[k], 1'b0);
    chk1("entry_err", err_s[k], 1'b0);
    chk("entry_csum", checksum_s[k], 32'h0);
    chk("entry_wl", 32'(words_loaded_s[k]), 32'h0);

    wsum = 32'h0;
    i    = 0;
    cyc  = 0;
    while (i < len && cyc < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      s_valid_s[k] = v;
      s_data_s[k]  = v ? words[i] : $urandom;
      #1;
      chk1("load_ready", s_ready_s[k], 1'b1);
      chk1("load_sel", ext_sel_s[k], 1'b1);
      chk1("load_we", ext_we_s[k], v);
      chk("load_addr", ext_addr_s[k], exp_addr(k, i));
      if (v) chk("load_wdata", ext_wdata_s[k], words[i]);
      chk("load_wl", 32'(words_loaded_s[k]), 32'(i));
      chk("load_csum", checksum_s[k], wsum);
      @(negedge clk);
      if (v) begin
        wsum = wsum + words[i];
        i++;
      end
      cyc++;
    end
    s_valid_s[k] = 1'b0;
    chk("handshakes", 32'(i), 32'(len));

    rsum = 32'h0;
    for (int j = 0; j < len; j++) begin
      #1;
      chk1("verify_ready", s_ready_s[k], 1'b0);
      chk1("verify_we", ext_we_s[k], 1'b0);
      chk1("verify_sel", ext_sel_s[k], 1'b1);
      chk1("verify_done", done_s[k], 1'b0);
      chk("verify_addr", ext_addr_s[k], exp_addr(k, j));
      if (j == abort_at) begin
        reset_s[k] = 1'b1;
        @(negedge clk);
        reset_s[k] = 1'b0;
        #1;
        chk1("abort_sel", ext_sel_s[k], 1'b0);
        chk1("abort_hold", cpu_hold_s[k], 1'b1);
        chk1("abort_done", done_s[k], 1'b0);
        chk1("abort_err", err_s[k], 1'b0);
        chk1("abort_ready", s_ready_s[k], 1'b0);
        chk("abort_csum", checksum_s[k], 32'h0);
        chk("abort_wl", 32'(words_loaded_s[k]), 32'h0);
        chk("abort_addr", ext_addr_s[k], base_of(k));
        model_run[k] = 1'b0;
        $display("[TB] load inst=%0d req=%0d len=%0d reset during verify word %0d -> idle",
                 k, req, len, j);
        return;
      end
      rv = (corrupt_en && corrupt_inst == k && exp_addr(k, j) == corrupt_addr) ?
           corrupt_val : words[j];
      rsum = rsum + rv;
      @(negedge clk);
    end

    // compare cycle
    #1;
    chk1("check_done", done_s[k], 1'b0);
    chk1("check_hold", cpu_hold_s[k], 1'b1);
    @(negedge clk);
    #1;

    exp_ok = (rsum == wsum);
    chk1("final_done", done_s[k], exp_ok);
    chk1("final_err", err_s[k], !exp_ok);
    chk1("final_hold", cpu_hold_s[k], !exp_ok);
    chk1("final_sel", ext_sel_s[k], 1'b0);
    chk("final_csum", checksum_s[k], wsum);
    chk("final_wl", 32'(words_loaded_s[k]), 32'(len));

    s_valid_s[k] = 1'b1;
    #1;
    chk1("idle_we_forced_low", ext_we_s[k], 1'b0);
    chk1("idle_ready", s_ready_s[k], 1'b0);
    s_valid_s[k] = 1'b0;

    chk("write_count", 32'(wlog.size() - wr0), 32'(len));
    for (int n = 0; n < len && (wr0 + n) < wlog.size(); n++) begin
      e = wlog[wr0 + n];
      chk("write_inst", 32'(e.k), 32'(k));
      chk("write_addr", e.addr, exp_addr(k, n));
      chk("write_data", e.data, words[n]);
    end

    model_run[k] = exp_ok;
    $display("[TB] load inst=%0d req=%0d len=%0d mode=%0d wsum=%08h rsum=%08h -> %s",
             k, req, len, mode, wsum, rsum, exp_ok ? "run" : "error-hold");
  endtask

  initial begin
    int rlen;

    corrupt_en   = 1'b0;
    corrupt_inst = 0;
    corrupt_addr = 32'h0;
    corrupt_val  = 32'h0;
    for (int k = 0; k < NI; k++) begin
      reset_s[k]    = 1'b1;
      start_s[k]    = 1'b0;
      load_len_s[k] = 8'd0;
      s_valid_s[k]  = 1'b0;
      s_data_s[k]   = '0;
      model_run[k]  = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) reset_s[k] = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk1("rst_hold", cpu_hold_s[k], 1'b1);
      chk1("rst_sel", ext_sel_s[k], 1'b0);
      chk1("rst_we", ext_we_s[k], 1'b0);
      chk1("rst_ready", s_ready_s[k], 1'b0);
      chk1("rst_done", done_s[k], 1'b0);
      chk1("rst_err", err_s[k], 1'b0);
      chk("rst_csum", checksum_s[k], 32'h0);
      chk("rst_wl", 32'(words_loaded_s[k]), 32'h0);
      chk("rst_addr", ext_addr_s[k], base_of(k));
      chk("rst_wdata", ext_wdata_s[k], 32'h0);
    end
    $display("[TB] reset and idle checked on both instances");

    // four fixed words at full throughput
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    run_load(0, 4, 0, -1);
    chk("fixed_csum_aa", checksum_s[0], 32'hAA);

    // same words, s_valid toggling; reload straight from RUN
    run_load(0, 4, 1, -1);
    chk1("toggle_done", done_s[0], 1'b1);

    // corrupted read-back of 0x8 -> mismatch
    corrupt_en   = 1'b1;
    corrupt_inst = 0;
    corrupt_addr = 32'h8;
    corrupt_val  = 32'h34;
    run_load(0, 4, 0, -1);
    chk1("corrupt_err", err_s[0], 1'b1);
    chk1("corrupt_done", done_s[0], 1'b0);
    corrupt_en = 1'b0;

    // recovery from the error state with a single word
    words[0] = $urandom;
    run_load(0, 1, 0, -1);

    // empty load
    run_load(0, 0, 0, -1);

    // oversize request on BASE=0x100: clamped to DEPTH, address wraps
    for (int n = 0; n < 256; n++) words[n] = $urandom;
    run_load(1, 200, 2, -1);
    chk("wrap_wl", 32'(words_loaded_s[1]), 32'd128);

    // reset during VERIFY word 2
    words[0] = 32'h5; words[1] = 32'h6; words[2] = 32'h7; words[3] = 32'h8;
    run_load(0, 4, 0, 2);

    // randomised loads, some with a corrupted read-back word
    for (int r = 0; r < 8; r++) begin
      rlen = $urandom_range(1, 24);
      for (int n = 0; n < rlen; n++) words[n] = $urandom;
      corrupt_en   = 1'($urandom_range(0, 1));
      corrupt_inst = r % NI;
      corrupt_addr = exp_addr(r % NI, $urandom_range(0, rlen - 1));
      corrupt_val  = $urandom;
      run_load(r % NI, rlen, $urandom_range(0, 2), -1);
    end
    corrupt_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader_ctrl.md
Name: imem_loader_ctrl

Overview:
- Boot/program-load controller for the multicycle RISC-V core's shared data memory.
- Holds the core in reset and takes ownership of the external address/data/write-enable path into dmem (the IEA/IED/XWE mux selects).
- Streams host words into consecutive word addresses, then re-reads them and compares checksums.
- On a checksum match, releases the core to run. On a mismatch, flags an error and keeps the core held.

Parameters:
- Width, 32, data and address width.
- DEPTH, 128, dmem size in words (7-bit word index, byte address bits [8:2]).
- BASE, 0, byte address of the first loaded word; must be word-aligned.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; begins a load
- load_len  in  8  number of words to load; sampled on start
- s_valid  in  1  host word valid
- s_data  in  Width  host word
- s_ready  out  1  controller accepts s_data this cycle
- rdata  in  Width  dmem ReadData (asynchronous read of ext_addr)
- ext_sel  out  1  drives IEA/IED/XWE selects; 1 = controller owns dmem
- ext_we  out  1  dmem write enable on the external path
- ext_addr  out  Width  dmem byte address
- ext_wdata  out  Width  dmem write data
- cpu_hold  out  1  OR'd into the core reset
- done  out  1  load verified, core running
- err  out  1  verify mismatch
- checksum  out  Width  modulo-2^Width sum of the written words
- words_loaded  out  8  handshakes accepted in the current load

Behaviour:
- Reset (synchronous, one cycle):
  - state=IDLE; cpu_hold=1; ext_sel=0; ext_we=0; s_ready=0; done=0; err=0.
  - checksum=0; words_loaded=0; ext_addr=BASE; ext_wdata=0.
- States: IDLE, LOAD, VERIFY, CHECK, RUN, FAIL.
- Length latch: on start, len=min(load_len, DEPTH). This length is used for the whole load.
- IDLE:
  - cpu_hold=1, ext_sel=0.
  - start with len=0 -> RUN (checksum=0, no writes).
  - start with len>0 -> LOAD; clears index, checksum, words_loaded and err.
- LOAD:
  - ext_sel=1, s_ready=1.
  - ext_we = s_valid (combinational, same cycle); ext_wdata=s_data; ext_addr=BASE+4*idx.
  - On each handshake: idx++, words_loaded++, checksum+=s_data (wraps modulo 2^Width).
  - s_valid low -> no write; state and address are held.
  - Handshake on word len-1 -> VERIFY with idx=0. s_ready drops the following cycle.
  - start is ignored in LOAD and VERIFY.
- VERIFY:
  - ext_sel=1, ext_we=0, s_ready=0.
  - One word per cycle: ext_addr=BASE+4*idx; rsum+=rdata sampled at the clock edge; idx++.
  - After len cycles -> CHECK.
- CHECK (one cycle):
  - rsum==checksum -> RUN.
  - Otherwise -> FAIL.
- RUN:
  - cpu_hold=0, ext_sel=0, done=1.
  - start -> LOAD (reload); done and cpu_hold=1 take effect the next cycle.
- FAIL:
  - cpu_hold=1, ext_sel=0, err=1 (held).
  - start -> LOAD; err clears on entry to LOAD.
- Address arithmetic:
  - Word index is modulo DEPTH: ext_addr = BASE + ((idx mod DEPTH)<<2).
  - Bits [1:0] are always 0; bits above [8:2] come from BASE only.
  - With len=DEPTH and BASE!=0, the address wraps to low memory and never exceeds the dmem window.
- Outputs ext_addr, ext_wdata and ext_we are only meaningful while ext_sel=1. When ext_sel=0, ext_we is forced to 0.
- Reset mid-operation (any state) -> IDLE next cycle. Memory contents are undefined; cpu_hold=1.
- Latency:
  - Start to first write possible: 1 cycle.
  - n words at full throughput: n LOAD + n VERIFY + 1 CHECK cycles.
  - Core release (cpu_hold low) on the cycle after CHECK.

Test Plan:
- Reset, then idle 5 cycles -> cpu_hold=1, ext_sel=0, done=0, err=0, checksum=0.
- start, load_len=4, data 0x11,0x22,0x33,0x44 with s_valid held high; bench dmem model -> writes at 0x0,0x4,0x8,0xC; checksum=0xAA; done=1 after 4+4+1 cycles; cpu_hold=0.
- Same 4 words with s_valid toggling on alternate cycles -> no write on idle cycles, addresses unchanged; final done=1, words_loaded=4.
- Bench corrupts readback of address 0x8 to 0x34 -> CHECK fails; err=1, cpu_hold=1, done=0. A following start with load_len=1 -> err cleared on LOAD entry.
- load_len=0 -> RUN on the next cycle with no ext_we pulse. load_len=200 with BASE=0x100 -> len=128; addresses wrap 0x1FC -> 0x000; words_loaded=128.
- Reset asserted during VERIFY word 2 -> IDLE next cycle, ext_sel=0, cpu_hold=1. In RUN, start -> LOAD with cpu_hold=1 one cycle later.
